req_encoder_8to3: RTL and testbench

- Sequential 8-to-3 request encoder; the inverse of the team's 3-to-8 binary decoder.
- Collects up to eight request lines into a pending register.
- Emits the 3-bit index of one pending request at a time over a valid/ready handshake, then clears the serviced bit.
- Sits between interrupt or event sources and a consumer that expects binary-coded indices, e.g. a decoder that re-expands the index downstream.

---
 rtl/req_encoder_8to3.sv | 102 ++++++++++
 tb/tb_req_encoder_8to3.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/req_encoder_8to3.sv
// Sequential 8-to-3 request encoder: latches request lines into a pending register and
// presents one binary index at a time over a valid/ready handshake.
module req_encoder_8to3 #(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [2:0] code,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] pending
);

  typedef enum logic [0:0] {StIdle, StPresent} state_e;

  state_e     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [2:0] code_q, code_d;
  logic [2:0] rr_ptr_q, rr_ptr_d;

  logic       accept;
  logic [7:0] clr;
  logic [7:0] avail;
  logic [2:0] sel;
  logic       sel_found;
  logic [2:0] idx;

  assign accept = valid && ready;
  assign clr    = accept ? (8'b1 << code_q) : 8'h00;
  // Selection looks only at pre-edge pending bits; a fresh req is picked up one edge later.
  assign avail  = pending_q & ~clr;

  always_comb begin
    sel       = 3'd0;
    sel_found = 1'b0;
    idx       = 3'd0;
    if (ROUND_ROBIN) begin
      for (int unsigned k = 0; k < 8; k++) begin
        idx = rr_ptr_q + 3'(k) + 3'd1;
        if (!sel_found && avail[idx]) begin
          sel_found = 1'b1;
          sel       = idx;
        end
      end
    end else begin
      for (int k = 7; k >= 0; k--) begin
        if (avail[k]) begin
          sel_found = 1'b1;
          sel       = 3'(k);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= 8'h00;
      code_q    <= 3'd0;
      rr_ptr_q  <= 3'd7;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    // A new req on the bit being cleared wins, so that index comes round again.
    pending_d = (pending_q & ~clr) | req;
    rr_ptr_d  = accept ? code_q : rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          code_d  = sel;
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (ready) begin
          if (sel_found) begin
            code_d = sel;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    valid   = (state_q == StPresent);
    code    = code_q;
    pending = pending_q;
  end

endmodule

// File: tb/tb_req_encoder_8to3.sv
// Bench for req_encoder_8to3: fixed-priority and round-robin instances checked against
// directed vector tables, hand sequences and a behavioural model under random traffic.
module tb_req_encoder_8to3;

  logic       clk, rst;
  logic [7:0] req0, req1;
  logic       ready0, ready1;
  logic [2:0] code0, code1;
  logic       valid0, valid1;
  logic [7:0] pend0, pend1;

  int tests = 0;
  int fails = 0;

  int unsigned m_pend[2];
  int unsigned m_code[2];
  int unsigned m_ptr[2];
  bit          m_valid[2];

  typedef struct {
    logic [7:0] req;
    logic       rdy;
    logic       v;
    logic [2:0] c;
    logic [7:0] p;
  } vec_t;

  vec_t tbl[24];

  req_encoder_8to3 #(.ROUND_ROBIN(1'b0)) dut_fixed (
    .clk(clk), .rst(rst), .req(req0), .code(code0), .valid(valid0), .ready(ready0),
    .pending(pend0)
  );

  req_encoder_8to3 #(.ROUND_ROBIN(1'b1)) dut_rr (
    .clk(clk), .rst(rst), .req(req1), .code(code1), .valid(valid1), .ready(ready1),
    .pending(pend1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i]  = 0;
      m_code[i]  = 0;
      m_ptr[i]   = 7;
      m_valid[i] = 1'b0;
    end
  endtask

  // Advance one clock; the model applies the handshake rules to both instances.
  task automatic cycle();
    int unsigned np[2], nc[2], nptr[2];
    bit          nv[2];
    int unsigned rq[2];
    bit          rd[2];
    rq[0] = req0;
    rq[1] = req1;
    rd[0] = ready0;
    rd[1] = ready1;
    for (int i = 0; i < 2; i++) begin
      bit          acc, found;
      int unsigned clr, avail, sel, idx;
      acc   = m_valid[i] && rd[i];
      clr   = acc ? (32'd1 << m_code[i]) : 0;
      avail = m_pend[i] & ~clr & 32'hFF;
      found = 1'b0;
      sel   = 0;
      for (int k = 0; k < 8; k++) begin
        idx = (i == 0) ? k : (m_ptr[i] + 1 + k) % 8;
        if (!found && ((avail >> idx) & 1) == 1) begin
          found = 1'b1;
          sel   = idx;
        end
      end
      np[i]   = ((m_pend[i] & ~clr) | rq[i]) & 32'hFF;
      nv[i]   = m_valid[i];
      nc[i]   = m_code[i];
      nptr[i] = acc ? m_code[i] : m_ptr[i];
      if (!m_valid[i]) begin
        if (avail != 0) begin
          nv[i] = 1'b1;
          nc[i] = sel;
        end
      end else if (rd[i]) begin
        if (avail != 0) nc[i] = sel;
        else nv[i] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      m_pend[i]  = np[i];
      m_valid[i] = nv[i];
      m_code[i]  = nc[i];
      m_ptr[i]   = nptr[i];
    end
    chk("fixed_valid", valid0, m_valid[0]);
    chk("fixed_code", code0, m_code[0]);
    chk("fixed_pending", pend0, m_pend[0]);
    chk("rr_valid", valid1, m_valid[1]);
    chk("rr_code", code1, m_code[1]);
    chk("rr_pending", pend1, m_pend[1]);
  endtask

  task automatic setv(input int i, input logic [7:0] r, input logic rdy, input logic v,
                      input logic [2:0] c, input logic [7:0] p);
    tbl[i].req = r;
    tbl[i].rdy = rdy;
    tbl[i].v   = v;
    tbl[i].c   = c;
    tbl[i].p   = p;
  endtask

  initial begin
    int prev;
    // Single request, two requests in a burst, backpressure, same-bit collision.
    setv(0,  8'h20, 1'b1, 1'b0, 3'd0, 8'h20);
    setv(1,  8'h00, 1'b1, 1'b1, 3'd5, 8'h20);
    setv(2,  8'h00, 1'b1, 1'b0, 3'd5, 8'h00);
    setv(3,  8'h00, 1'b1, 1'b0, 3'd5, 8'h00);
    setv(4,  8'hA4, 1'b1, 1'b0, 3'd5, 8'hA4);
    setv(5,  8'h00, 1'b1, 1'b1, 3'd2, 8'hA4);
    setv(6,  8'h00, 1'b1, 1'b1, 3'd5, 8'hA0);
    setv(7,  8'h00, 1'b1, 1'b1, 3'd7, 8'h80);
    setv(8,  8'h00, 1'b1, 1'b0, 3'd7, 8'h00);
    setv(9,  8'h00, 1'b1, 1'b0, 3'd7, 8'h00);
    setv(10, 8'h81, 1'b0, 1'b0, 3'd7, 8'h81);
    setv(11, 8'h00, 1'b0, 1'b1, 3'd0, 8'h81);
    setv(12, 8'h02, 1'b0, 1'b1, 3'd0, 8'h83);
    setv(13, 8'h00, 1'b0, 1'b1, 3'd0, 8'h83);
    setv(14, 8'h00, 1'b0, 1'b1, 3'd0, 8'h83);
    setv(15, 8'h00, 1'b0, 1'b1, 3'd0, 8'h83);
    setv(16, 8'h00, 1'b1, 1'b1, 3'd1, 8'h82);
    setv(17, 8'h00, 1'b1, 1'b1, 3'd7, 8'h80);
    setv(18, 8'h00, 1'b1, 1'b0, 3'd7, 8'h00);
    setv(19, 8'h08, 1'b0, 1'b0, 3'd7, 8'h08);
    setv(20, 8'h00, 1'b0, 1'b1, 3'd3, 8'h08);
    setv(21, 8'h08, 1'b1, 1'b0, 3'd3, 8'h08);
    setv(22, 8'h00, 1'b1, 1'b1, 3'd3, 8'h08);
    setv(23, 8'h00, 1'b1, 1'b0, 3'd3, 8'h00);

    rst    = 1'b1;
    req0   = 8'h00;
    req1   = 8'h00;
    ready0 = 1'b0;
    ready1 = 1'b0;
    #12;
    chk("reset_valid0", valid0, 0);
    chk("reset_code0", code0, 0);
    chk("reset_pending0", pend0, 0);
    chk("reset_valid1", valid1, 0);
    chk("reset_code1", code1, 0);
    chk("reset_pending1", pend1, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      req0   = tbl[i].req;
      ready0 = tbl[i].rdy;
      cycle();
      chk($sformatf("tbl%0d_valid", i), valid0, tbl[i].v);
      chk($sformatf("tbl%0d_code", i), code0, tbl[i].c);
      chk($sformatf("tbl%0d_pending", i), pend0, tbl[i].p);
    end
    req0   = 8'h00;
    ready0 = 1'b0;

    // Reset asserted between edges while presenting with pending=F0.
    req0 = 8'hF0;
    cycle();
    req0 = 8'h00;
    cycle();
    chk("pre_rst_valid", valid0, 1);
    chk("pre_rst_pending", pend0, 8'hF0);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", valid0, 0);
    chk("async_rst_code", code0, 0);
    chk("async_rst_pending", pend0, 0);
    model_reset();
    #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("post_rst_idle", valid0, 0);
    end

    // Round-robin with all requests held: 0..7 then wrap.
    req1   = 8'hFF;
    ready1 = 1'b1;
    cycle();
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("rr_all_valid", valid1, 1);
      chk($sformatf("rr_all_code%0d", k), code1, k % 8);
    end
    req1 = 8'h11;
    for (int k = 0; k < 12; k++) cycle();
    for (int k = 0; k < 4; k++) begin
      prev = code1;
      cycle();
      chk("rr_alt_in_set", (code1 == 0 || code1 == 4) ? 1 : 0, 1);
      chk("rr_alt_toggle", (code1 != prev) ? 1 : 0, 1);
    end
    req1   = 8'h00;
    ready1 = 1'b0;

    // Random traffic on both instances against the model.
    for (int n = 0; n < 1500; n++) begin
      req0   = 8'($urandom & $urandom & $urandom);
      req1   = 8'($urandom & $urandom & $urandom);
      ready0 = ($urandom_range(0, 3) != 0);
      ready1 = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
